// File: rtl/rvm_mem_bridge.sv
// Purpose: turns the core's stall-style memory port into a split request/response valid-ready bus.
//          Misaligned addresses are rejected locally, and a response timeout is reported as an error.
// Latency: 4 cycles minimum for an aligned access on a zero-wait bus (IDLE, REQ, RSP, DONE).
//          A misaligned access takes 2 cycles (IDLE, DONE).
// Backpressure: the request is held until bus_req_ready, and the core is stalled until DONE.
//          Responses are always accepted in RSP and ignored in every other state.
//
// Ports:
//   clk, reset                         rising-edge clock; synchronous active-high reset
//   mem_addr/wdata/c_en/b_en           core access (b_en == 0 means read)
//   mem_rdata/error/stall              core completion data, error flag and hold request
//   bus_req_valid/ready/addr/wdata/wstrb/write   request channel
//   bus_rsp_valid/rdata/error          response channel (no ready)

module rvm_mem_bridge #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_c_en,
    input  logic [3:0]  mem_b_en,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_stall,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    output logic        bus_req_write,

    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Last count value spent in RSP.
    // Reaching it without a response aborts the access,
    // so DONE lands exactly TIMEOUT cycles after RSP is entered.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q,  req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic        req_write_q, req_write_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        error_q,     error_d;
    logic [7:0]  cnt_q,       cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_wstrb_q <= 4'd0;
            req_write_q <= 1'b0;
            rdata_q     <= 32'd0;
            error_q     <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            req_write_q <= req_write_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        req_write_d = req_write_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_c_en) begin
                    if (mem_addr[1:0] != 2'b00) begin
                        // Rejected locally: nothing goes out on the bus.
                        error_d = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_DONE;
                    end else begin
                        req_addr_d  = mem_addr;
                        req_wdata_d = mem_wdata;
                        req_wstrb_d = mem_b_en;
                        req_write_d = (mem_b_en != 4'b0000);
                        req_valid_d = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                // No timeout here: once raised, valid stays up until accepted.
                if (bus_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (bus_rsp_valid) begin
                    rdata_d = req_write_q ? 32'd0 : bus_rsp_rdata;
                    error_d = bus_rsp_error;
                    state_d = ST_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    error_d = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_req_valid = req_valid_q;
    assign bus_req_addr  = req_addr_q;
    assign bus_req_wdata = req_wdata_q;
    assign bus_req_wstrb = req_wstrb_q;
    assign bus_req_write = req_write_q;

    assign mem_rdata = rdata_q;
    assign mem_error = error_q & (state_q == ST_DONE);
    assign mem_stall = mem_c_en & (state_q != ST_DONE);

endmodule

// File: tb/tb_rvm_mem_bridge.sv
// Purpose: directed self-checking bench for rvm_mem_bridge (instantiated with TIMEOUT=4).
// Latency: inputs are driven and outputs sampled on the falling edge, away from the active edge.
// Backpressure: bus_req_ready is held low to stretch REQ, and bus_rsp_valid is withheld to force a timeout.

module tb_rvm_mem_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic [3:0]  mem_b_en;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_stall;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_req_write;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_error;

    int total = 0;
    int bad   = 0;

    rvm_mem_bridge #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_c_en      (mem_c_en),
        .mem_b_en      (mem_b_en),
        .mem_rdata     (mem_rdata),
        .mem_error     (mem_error),
        .mem_stall     (mem_stall),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wstrb (bus_req_wstrb),
        .bus_req_write (bus_req_write),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_error (bus_rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait access: ready is high in REQ and the response arrives in the first RSP cycle.
    // With keep=1, mem_c_en stays high through DONE, so the next call is a back-to-back access.
    task automatic do_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] ben, input logic [31:0] rsp_rdata, input logic rsp_err,
                             input logic [31:0] exp_rdata, input logic exp_err, input bit keep);
        @(negedge clk);
        mem_c_en      = 1'b1;
        mem_addr      = addr;
        mem_wdata     = wdata;
        mem_b_en      = ben;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        #1;
        chk({tag, ".c0_stall"}, 32'(mem_stall), 32'd1);
        @(negedge clk);
        #1;
        chk({tag, ".req_valid"}, 32'(bus_req_valid), 32'd1);
        chk({tag, ".req_addr"}, bus_req_addr, addr);
        chk({tag, ".req_wstrb"}, 32'(bus_req_wstrb), 32'(ben));
        chk({tag, ".req_write"}, 32'(bus_req_write), (ben != 4'b0000) ? 32'd1 : 32'd0);
        chk({tag, ".c1_stall"}, 32'(mem_stall), 32'd1);
        @(negedge clk);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = rsp_rdata;
        bus_rsp_error = rsp_err;
        #1;
        chk({tag, ".rsp_valid_dropped"}, 32'(bus_req_valid), 32'd0);
        chk({tag, ".c2_stall"}, 32'(mem_stall), 32'd1);
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        bus_rsp_error = 1'b0;
        mem_c_en      = keep;
        #1;
        chk({tag, ".done_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, ".done_rdata"}, mem_rdata, exp_rdata);
        chk({tag, ".done_error"}, 32'(mem_error), 32'(exp_err));
        if (!keep) begin
            @(negedge clk);
            #1;
            chk({tag, ".after_error"}, 32'(mem_error), 32'd0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        mem_c_en      = 1'b0;
        mem_b_en      = 4'd0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'd0;
        bus_rsp_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.req_valid", 32'(bus_req_valid), 32'd0);
        chk("rst.req_addr",  bus_req_addr, 32'd0);
        chk("rst.req_wdata", bus_req_wdata, 32'd0);
        chk("rst.req_wstrb", 32'(bus_req_wstrb), 32'd0);
        chk("rst.req_write", 32'(bus_req_write), 32'd0);
        chk("rst.rdata",     mem_rdata, 32'd0);
        chk("rst.error",     32'(mem_error), 32'd0);
        chk("rst.stall",     32'(mem_stall), 32'd0);

        // Zero-wait read.
        do_access("rd0", 32'h0000_0100, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Write with ready held low for 5 cycles: valid stays up for 6 cycles.
        // The response carries rdata, which a write must not return.
        @(negedge clk);
        bus_req_ready = 1'b0;
        mem_c_en      = 1'b1;
        mem_addr      = 32'h0000_0204;
        mem_wdata     = 32'h1234_5678;
        mem_b_en      = 4'b0011;
        #1;
        chk("wr.c0_stall", 32'(mem_stall), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) bus_req_ready = 1'b1;
            #1;
            chk($sformatf("wr.valid%0d", i), 32'(bus_req_valid), 32'd1);
            chk($sformatf("wr.addr%0d", i), bus_req_addr, 32'h0000_0204);
            chk($sformatf("wr.wdata%0d", i), bus_req_wdata, 32'h1234_5678);
            chk($sformatf("wr.wstrb%0d", i), 32'(bus_req_wstrb), 32'h3);
            chk($sformatf("wr.write%0d", i), 32'(bus_req_write), 32'd1);
            chk($sformatf("wr.stall%0d", i), 32'(mem_stall), 32'd1);
        end
        @(negedge clk);
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hAAAA_5555;
        #1;
        chk("wr.valid_dropped", 32'(bus_req_valid), 32'd0);
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        mem_c_en      = 1'b0;
        #1;
        chk("wr.done_rdata", mem_rdata, 32'd0);
        chk("wr.done_error", 32'(mem_error), 32'd0);
        chk("wr.done_stall", 32'(mem_stall), 32'd0);

        // Misaligned read: no bus request, error in the next cycle only.
        @(negedge clk);
        mem_c_en = 1'b1;
        mem_addr = 32'h0000_0102;
        mem_b_en = 4'b0000;
        #1;
        chk("mis.c0_stall", 32'(mem_stall), 32'd1);
        chk("mis.c0_valid", 32'(bus_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("mis.done_error", 32'(mem_error), 32'd1);
        chk("mis.done_stall", 32'(mem_stall), 32'd0);
        chk("mis.done_valid", 32'(bus_req_valid), 32'd0);
        mem_c_en = 1'b0;
        @(negedge clk);
        #1;
        chk("mis.after_error", 32'(mem_error), 32'd0);
        chk("mis.after_valid", 32'(bus_req_valid), 32'd0);

        // Write that returns a bus error.
        do_access("werr", 32'h0000_0208, 32'hCAFE_0001, 4'b1111, 32'h5555_AAAA, 1'b1, 32'd0, 1'b1, 1'b0);

        // Timeout: accepted read with no response; DONE comes 4 cycles after entering RSP.
        @(negedge clk);
        mem_c_en      = 1'b1;
        mem_addr      = 32'h0000_0300;
        mem_b_en      = 4'b0000;
        bus_req_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("to.req_valid", 32'(bus_req_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to.rsp%0d_stall", i), 32'(mem_stall), 32'd1);
            chk($sformatf("to.rsp%0d_error", i), 32'(mem_error), 32'd0);
        end
        @(negedge clk);
        mem_c_en = 1'b0;
        #1;
        chk("to.done_error", 32'(mem_error), 32'd1);
        chk("to.done_rdata", mem_rdata, 32'd0);
        chk("to.done_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hBADB_AD00;
        #1;
        chk("to.late_error", 32'(mem_error), 32'd0);
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        #1;
        chk("to.late_rdata", mem_rdata, 32'd0);
        chk("to.late_error2", 32'(mem_error), 32'd0);
        do_access("to.next", 32'h0000_0400, 32'd0, 4'b0000, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Reset while in RSP, then a stale response, then back-to-back accesses.
        @(negedge clk);
        mem_c_en      = 1'b1;
        mem_addr      = 32'h0000_0500;
        mem_wdata     = 32'h7777_7777;
        mem_b_en      = 4'b1000;
        bus_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rr.in_rsp_stall", 32'(mem_stall), 32'd1);
        reset    = 1'b1;
        mem_c_en = 1'b0;
        @(negedge clk);
        reset         = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h9999_9999;
        #1;
        chk("rr.req_valid", 32'(bus_req_valid), 32'd0);
        chk("rr.req_addr",  bus_req_addr, 32'd0);
        chk("rr.req_wdata", bus_req_wdata, 32'd0);
        chk("rr.req_wstrb", 32'(bus_req_wstrb), 32'd0);
        chk("rr.req_write", 32'(bus_req_write), 32'd0);
        chk("rr.rdata",     mem_rdata, 32'd0);
        chk("rr.error",     32'(mem_error), 32'd0);
        chk("rr.stall",     32'(mem_stall), 32'd0);
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        #1;
        chk("rr.stale_rdata", mem_rdata, 32'd0);
        chk("rr.stale_error", 32'(mem_error), 32'd0);
        chk("rr.stale_valid", 32'(bus_req_valid), 32'd0);
        do_access("rr.b2b0", 32'h0000_0600, 32'd0, 4'b0000, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0, 1'b1);
        do_access("rr.b2b1", 32'h0000_0604, 32'h2468_ACE0, 4'b0100, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
